// File: rtl/cory_merge16_pkg.sv
// Shared constants and types for the 16-input round-robin merge.
package cory_merge16_pkg;
   localparam int CORY_MERGE16_PORTS = 16;
   localparam int CORY_MERGE16_IDX_W = 4;

   typedef logic [CORY_MERGE16_IDX_W-1:0] idx_t;
   typedef logic [CORY_MERGE16_PORTS-1:0] port_vec_t;
endpackage

// File: rtl/cory_rr_arb16.sv
// Round-robin grant: first request at or above ptr, ascending modulo 16.
module cory_rr_arb16
   import cory_merge16_pkg::*;
(
   input  port_vec_t req,
   input  idx_t      ptr,
   output port_vec_t gnt,
   output idx_t      gnt_idx,
   output logic      gnt_vld
);

   always_comb begin
      idx_t k;
      k       = '0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int i = 0; i < CORY_MERGE16_PORTS; i++) begin
         // idx_t arithmetic wraps naturally at 16
         k = ptr + CORY_MERGE16_IDX_W'(i);
         if (!gnt_vld && req[k]) begin
            gnt[k]  = 1'b1;
            gnt_idx = k;
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cory_merge16.sv
// 16-to-1 round-robin merge with a one-entry output register.
// Optional skid register (registered ready) enabled by CORY_MERGE16_SKID_EN.
module cory_merge16
   import cory_merge16_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [CORY_MERGE16_PORTS-1:0]   i_a_v,
   input  logic [CORY_MERGE16_PORTS*N-1:0] i_a_d,
   output logic [CORY_MERGE16_PORTS-1:0]   o_a_r,
   output logic                            o_z_v,
   output logic [N-1:0]                    o_z_d,
   output logic [CORY_MERGE16_IDX_W-1:0]   o_z_s,
   input  logic                            i_z_r
);

   idx_t           ptr;
   port_vec_t      gnt;
   idx_t           gnt_idx;
   logic           gnt_vld;
   logic           can_acc;
   logic           in_xfer;
   logic [N-1:0]   in_d;

   cory_rr_arb16 u_arb (
      .req     (i_a_v),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign in_d    = i_a_d[gnt_idx*N +: N];
   assign in_xfer = gnt_vld && can_acc && !reset;
   assign o_a_r   = in_xfer ? gnt : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        ptr <= '0;
      else if (in_xfer) ptr <= gnt_idx + idx_t'(1);
   end

`ifdef CORY_MERGE16_SKID_EN
   logic         skid_v;
   logic [N-1:0] skid_d;
   idx_t         skid_s;
   logic         out_free;

   // Ready comes only from the skid flag, so it never sees i_z_r
   assign can_acc  = !skid_v;
   assign out_free = !o_z_v || i_z_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_z_v  <= 1'b0;
         o_z_d  <= '0;
         o_z_s  <= '0;
         skid_v <= 1'b0;
         skid_d <= '0;
         skid_s <= '0;
      end else if (out_free) begin
         if (skid_v) begin
            o_z_v  <= 1'b1;
            o_z_d  <= skid_d;
            o_z_s  <= skid_s;
            skid_v <= 1'b0;
         end else if (in_xfer) begin
            o_z_v <= 1'b1;
            o_z_d <= in_d;
            o_z_s <= gnt_idx;
         end else begin
            o_z_v <= 1'b0;
         end
      end else if (in_xfer) begin
         // Output is stalled: park the word accepted this cycle
         skid_v <= 1'b1;
         skid_d <= in_d;
         skid_s <= gnt_idx;
      end
   end
`else
   assign can_acc = !o_z_v || i_z_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_z_v <= 1'b0;
         o_z_d <= '0;
         o_z_s <= '0;
      end else if (in_xfer) begin
         o_z_v <= 1'b1;
         o_z_d <= in_d;
         o_z_s <= gnt_idx;
      end else if (o_z_v && i_z_r) begin
         o_z_v <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_cory_merge16.sv
// Directed and scoreboarded bench for cory_merge16 (N=8).
module tb_cory_merge16;

   logic         clk;
   logic         reset;
   logic [15:0]  i_a_v;
   logic [127:0] i_a_d;
   logic [15:0]  o_a_r;
   logic         o_z_v;
   logic [7:0]   o_z_d;
   logic [3:0]   o_z_s;
   logic         i_z_r;

   int tests = 0;
   int fails = 0;

   cory_merge16 #(.N(8)) dut (
      .clk   (clk),
      .reset (reset),
      .i_a_v (i_a_v),
      .i_a_d (i_a_d),
      .o_a_r (o_a_r),
      .o_z_v (o_z_v),
      .o_z_d (o_z_d),
      .o_z_s (o_z_s),
      .i_z_r (i_z_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  seq_in  [16];
   logic [3:0]  seq_out [16];
   int          accepted, delivered;
   logic [15:0] r0, acc;

   initial begin
      reset = 1'b1;
      i_a_v = 16'hFFFF;
      i_a_d = '0;
      i_z_r = 1'b1;

      // reset state, even with every source requesting
      tick();
      chk("rst_zv", o_z_v, 0);
      chk("rst_zd", o_z_d, 0);
      chk("rst_zs", o_z_s, 0);
      chk("rst_ptr", dut.ptr, 0);
      chk("rst_ar", o_a_r, 0);

      // single source 5
      @(negedge clk);
      reset = 1'b0;
      i_a_v = 16'h0020;
      i_a_d[5*8 +: 8] = 8'h3C;
      #1;
      chk("single_ar", o_a_r, 16'h0020);
      tick();
      chk("single_zv", o_z_v, 1);
      chk("single_zd", o_z_d, 8'h3C);
      chk("single_zs", o_z_s, 5);
      chk("single_ptr", dut.ptr, 6);
      i_a_v = 16'h0000;
      tick();
      chk("single_drain_zv", o_z_v, 0);
      chk("single_idle_ptr", dut.ptr, 6);

      // all-request fairness from ptr=0
      reset = 1'b1;
      #1;
      reset = 1'b0;
      for (int k = 0; k < 16; k++) i_a_d[k*8 +: 8] = 8'h10 + 8'(k);
      i_a_v = 16'hFFFF;
      for (int c = 0; c < 17; c++) begin
         tick();
         chk($sformatf("fair_zs_%0d", c), o_z_s, c % 16);
         chk($sformatf("fair_zd_%0d", c), o_z_d, 8'h10 + (c % 16));
      end
      chk("fair_ptr", dut.ptr, 1);

      // wrap: grant 14 leaves ptr=15, then 0 and 1
      i_a_v = 16'h4000;
      tick();
      chk("wrap_g14", o_z_s, 14);
      chk("wrap_ptr15", dut.ptr, 15);
      i_a_v = 16'h0003;
      tick();
      chk("wrap_g0", o_z_s, 0);
      chk("wrap_ptr1", dut.ptr, 1);
      tick();
      chk("wrap_g1", o_z_s, 1);
      chk("wrap_ptr2", dut.ptr, 2);
      i_a_v = 16'h0000;
      tick();

      // stall: hold 0xA5/2 for 4 cycles while source 3 waits
      i_a_d[2*8 +: 8] = 8'hA5;
      i_a_d[3*8 +: 8] = 8'h5A;
      i_a_v = 16'h0004;
      tick();
      chk("stall_load_zd", o_z_d, 8'hA5);
      chk("stall_ptr3", dut.ptr, 3);
      i_z_r = 1'b0;
      i_a_v = 16'h0008;
      @(negedge clk);
`ifdef CORY_MERGE16_SKID_EN
      chk("stall_ar_skid", o_a_r, 16'h0008);
`else
      chk("stall_ar_block", o_a_r, 16'h0000);
`endif
      for (int c = 0; c < 4; c++) begin
         tick();
`ifdef CORY_MERGE16_SKID_EN
         i_a_v = 16'h0000;
         chk($sformatf("stall_ptr_%0d", c), dut.ptr, 4);
`else
         chk($sformatf("stall_ptr_%0d", c), dut.ptr, 3);
`endif
         chk($sformatf("stall_zv_%0d", c), o_z_v, 1);
         chk($sformatf("stall_zd_%0d", c), o_z_d, 8'hA5);
         chk($sformatf("stall_zs_%0d", c), o_z_s, 2);
      end
      i_z_r = 1'b1;
`ifndef CORY_MERGE16_SKID_EN
      @(negedge clk);
      chk("release_ar", o_a_r, 16'h0008);
`endif
      tick();
      i_a_v = 16'h0000;
      chk("release_zd", o_z_d, 8'h5A);
      chk("release_zs", o_z_s, 3);
      chk("release_ptr", dut.ptr, 4);
      tick();
      chk("release_nodup", o_z_v, 0);

      // reset mid-flight clears output asynchronously
      i_z_r = 1'b0;
      i_a_d[7*8 +: 8] = 8'h77;
      i_a_v = 16'h0080;
      tick();
      chk("mid_loaded", o_z_v, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_zv", o_z_v, 0);
      chk("mid_rst_zs", o_z_s, 0);
      chk("mid_rst_zd", o_z_d, 0);
      chk("mid_rst_ptr", dut.ptr, 0);
      chk("mid_rst_ar", o_a_r, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      i_z_r = 1'b1;
      i_a_v = 16'h0210;
      tick();
      chk("post_rst_zs", o_z_s, 4);
      chk("post_rst_zv", o_z_v, 1);
      i_a_v = 16'h0000;
      tick();

      // random traffic with per-source ordering scoreboard
      for (int k = 0; k < 16; k++) begin
         seq_in[k]  = '0;
         seq_out[k] = '0;
      end
      accepted  = 0;
      delivered = 0;
      for (int cyc = 0; cyc < 20000 && delivered < 1000; cyc++) begin
         i_a_v = 16'($urandom);
         i_z_r = 1'($urandom_range(0, 1));
         for (int k = 0; k < 16; k++) i_a_d[k*8 +: 8] = {4'(k), seq_in[k]};
`ifdef CORY_MERGE16_SKID_EN
         #1;
         r0 = o_a_r;
         i_z_r = ~i_z_r;
         #1;
         chk("ar_indep_zr", o_a_r, r0);
         i_z_r = ~i_z_r;
`endif
         @(negedge clk);
         chk("ar_onehot", 32'($onehot0(o_a_r)), 1);
         acc = o_a_r & i_a_v;
         for (int k = 0; k < 16; k++)
            if (acc[k]) begin
               seq_in[k] = seq_in[k] + 4'd1;
               accepted++;
            end
         if (o_z_v && i_z_r) begin
            chk("rand_order", o_z_d, {o_z_s, seq_out[o_z_s]});
            seq_out[o_z_s] = seq_out[o_z_s] + 4'd1;
            delivered++;
         end
         tick();
      end
      chk("rand_delivered", 32'(delivered >= 1000), 1);
      // drain and confirm nothing lost or invented
      i_a_v = 16'h0000;
      i_z_r = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (o_z_v) begin
            chk("drain_order", o_z_d, {o_z_s, seq_out[o_z_s]});
            seq_out[o_z_s] = seq_out[o_z_s] + 4'd1;
            delivered++;
         end
         tick();
      end
      chk("rand_balance", delivered, accepted);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cory_merge16.md
CORY_MERGE16 -- requirements
Module: cory_merge16

Interface
REQ-001 SHALL have parameter N, default 8: data width of every input and of the output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_a_v, input, 16 bits: bit k is the valid of source k.
REQ-005 SHALL have port i_a_d, input, 16*N bits: source k data at bits [k*N+N-1 : k*N].
REQ-006 SHALL have port o_a_r, output, 16 bits: bit k is the ready to source k.
REQ-007 SHALL have port o_z_v, output, 1 bit: merged output valid.
REQ-008 SHALL have port o_z_d, output, N bits: merged output data.
REQ-009 SHALL have port o_z_s, output, 4 bits: index of the source that produced o_z_d.
REQ-010 SHALL have port i_z_r, input, 1 bit: downstream ready.

Function
REQ-011 SHALL treat a transfer on any port as valid && ready in the same cycle.
REQ-012 SHALL arbitrate round-robin: search starts at pointer ptr (4 bits) and ascends modulo 16; the first k with i_a_v[k]=1 is granted.
REQ-013 SHALL assert at most one bit of o_a_r per cycle, only the granted bit, and only when the pipeline can accept (REQ-016/REQ-025).
REQ-014 SHALL set ptr to (granted k + 1) mod 16 only on an accepted input transfer; 15 wraps to 0.
REQ-015 SHALL leave ptr unchanged in cycles with no input transfer, including stalls and idle cycles.
REQ-016 SHALL hold a one-entry output register; "can accept" = !o_z_v || i_z_r.
REQ-017 SHALL load o_z_d and o_z_s from the granted source on transfer; o_z_v rises the next cycle (latency 1).
REQ-018 SHALL clear o_z_v on an output transfer with no simultaneous input transfer.
REQ-019 SHALL sustain one transfer per cycle on simultaneous input and output transfers.
REQ-020 SHALL keep o_z_v, o_z_d and o_z_s stable while o_z_v=1 && i_z_r=0.
REQ-021 SHALL re-evaluate the grant every cycle; a source that has not been accepted may withdraw its valid without error.

Reset
REQ-022 SHALL, while reset=1, force o_z_v=0, o_z_d=0, o_z_s=0, ptr=0 and every skid entry empty, regardless of clk.
REQ-023 SHALL drop any buffered word on reset asserted mid-operation; no partial transfer completes on the edge reset deasserts.
REQ-024 SHALL drive o_a_r=0 during reset.

Configuration
REQ-025 With CORY_MERGE16_SKID_EN defined: SHALL add a one-entry skid register; o_a_r depends only on registered state, "can accept" = skid empty; on a stall the skid captures the in-flight word, and it drains to the output register before new input; throughput stays 1/cycle.
REQ-026 Without CORY_MERGE16_SKID_EN: SHALL have no skid register; o_a_r combinationally depends on i_z_r per REQ-016.
REQ-027 SHALL present the same ordering, ptr behaviour and o_z_s semantics in both builds; only ready timing and latency under stall differ.

Structure
REQ-028 SHALL take constants CORY_MERGE16_PORTS=16 and CORY_MERGE16_IDX_W=4 from shared package cory_merge16_pkg.
REQ-029 SHALL place the round-robin grant logic (request vector, ptr in, one-hot grant and index out) in sub-module cory_rr_arb16.

Verification
REQ-030 Bench SHALL check single source: only i_a_v[5]=1, d=0x3C, i_z_r=1 -> next cycle o_z_v=1, o_z_d=0x3C, o_z_s=5; ptr becomes 6.
REQ-031 Bench SHALL check all-request fairness: i_a_v=0xFFFF held, i_z_r=1, ptr=0 after reset -> o_z_s sequence 0,1,...,15,0 on consecutive cycles.
REQ-032 Bench SHALL check wrap: ptr=15 (after a grant to 14), i_a_v=0x0003 -> grant 0, then 1; ptr becomes 1, then 2.
REQ-033 Bench SHALL check stall: o_z_v=1 holding 0xA5 from source 2, i_z_r=0 for 4 cycles, i_a_v[3]=1 -> output stable at 0xA5/2, ptr unchanged; after i_z_r=1, source 3 follows; no loss or duplication.
REQ-034 Bench SHALL check reset mid-flight: assert reset while o_z_v=1 -> o_z_v=0, o_z_s=0 immediately (asynchronously); first post-reset grant is the lowest active index.
REQ-035 Bench SHALL check skid build: with CORY_MERGE16_SKID_EN, random i_z_r at 50% with a 1000-word scoreboard -> o_a_r never combinationally follows i_z_r, all words delivered in per-source order.
